// File: rtl/operand_entry_fsm.sv
// Operand/opcode entry front-end: sync + debounce btn_n, one press per field, captures switches into ALU inputs.
// Capture lands DEBOUNCE_CYCLES+1 edges after sync flop 1 first samples the press; no backpressure, presses are never queued.
module operand_entry_fsm #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] switches,
  input  logic       btn_n,
  output logic [3:0] operand_a,
  output logic [3:0] operand_b,
  output logic [1:0] alu_op,
  output logic       valid,
  output logic [1:0] state_led,
  output logic       entry_strobe
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    ENTER_OP = 2'b10,
    RUN      = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  logic          btn_meta;
  logic          sync_btn;
  logic [3:0]    sw_meta;
  logic [3:0]    sync_sw;
  logic          deb_level;
  logic [CW-1:0] deb_cnt;
  logic          accept;
  logic          press;
  logic          cap_a;
  logic          cap_b;
  logic          cap_op;
  logic          capture;

  // Button idles high so its synchronizer resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b1;
      sync_btn <= 1'b1;
      sw_meta  <= 4'h0;
      sync_sw  <= 4'h0;
    end else begin
      btn_meta <= btn_n;
      sync_btn <= btn_meta;
      sw_meta  <= switches;
      sync_sw  <= sw_meta;
    end
  end

  assign accept = (sync_btn != deb_level) && (deb_cnt == CNT_LAST);
  assign press  = accept && deb_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (sync_btn == deb_level) begin
      deb_cnt <= '0;
    end else if (accept) begin
      deb_level <= sync_btn;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENTER_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_op     = 1'b0;
    case (state)
      ENTER_A: begin
        if (press) begin
          cap_a      = 1'b1;
          state_next = ENTER_B;
        end
      end
      ENTER_B: begin
        if (press) begin
          cap_b      = 1'b1;
          state_next = ENTER_OP;
        end
      end
      ENTER_OP: begin
        if (press) begin
          cap_op     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (press) begin
          state_next = ENTER_A;
        end
      end
      default: state_next = ENTER_A;
    endcase
  end

  assign capture = cap_a || cap_b || cap_op;

  // Fields only move on their own capture edge; re-entry leaves them on the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_a    <= 4'h0;
      operand_b    <= 4'h0;
      alu_op       <= 2'b00;
      valid        <= 1'b0;
      entry_strobe <= 1'b0;
    end else begin
      if (cap_a) begin
        operand_a <= sync_sw;
      end
      if (cap_b) begin
        operand_b <= sync_sw;
      end
      if (cap_op) begin
        alu_op <= sync_sw[1:0];
      end
      valid        <= (state_next == RUN);
      entry_strobe <= capture;
    end
  end

  assign state_led = state;

endmodule
